// File: rtl/dmem_access_arbiter_if.sv
// Bundle between requesters A/B, the external data memory and the arbiter.
// master = requester/memory side, slave = arbiter side.
interface dmem_access_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
);
    logic                  clear_req;
    logic                  init_done;

    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output clear_req,
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  init_done,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
    );

    modport slave (
        input  clear_req,
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output init_done,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
    );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Shares one 1W/1R data memory between requesters A and B with independent
// round-robin write/read arbitration and a zero-fill sweep on reset/clear.
module dmem_access_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input logic                 clk,
    input logic                 reset,
    dmem_access_arbiter_if.slave bus
);
    typedef enum logic {CLEAR, RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  wr_prio_q, wr_prio_d;
    logic                  rd_prio_q, rd_prio_d;
    logic                  a_pend_q, a_pend_d;
    logic                  b_pend_q, b_pend_d;
    logic                  byp_q, byp_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

    logic                  a_wc, b_wc, a_rc, b_rc;
    logic                  a_wg, b_wg, a_rg, b_rg;
    logic                  we_c, re_c;
    logic [ADDR_WIDTH-1:0] waddr_c, raddr_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [DATA_WIDTH-1:0] ret_data;

    assign a_wc = bus.a_req & bus.a_we;
    assign b_wc = bus.b_req & bus.b_we;
    assign a_rc = bus.a_req & ~bus.a_we;
    assign b_rc = bus.b_req & ~bus.b_we;

    // A same-address write in the read's grant cycle overrides memory data.
    assign ret_data = byp_q ? byp_data_q : bus.mem_rdata;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_prio_d  = wr_prio_q;
        rd_prio_d  = rd_prio_q;
        a_pend_d   = 1'b0;
        b_pend_d   = 1'b0;
        byp_d      = 1'b0;
        byp_data_d = byp_data_q;
        a_wg       = 1'b0;
        b_wg       = 1'b0;
        a_rg       = 1'b0;
        b_rg       = 1'b0;
        we_c       = 1'b0;
        re_c       = 1'b0;
        waddr_c    = '0;
        raddr_c    = '0;
        wdata_c    = '0;
        a_rdata_d  = a_pend_q ? ret_data : a_rdata_q;
        b_rdata_d  = b_pend_q ? ret_data : b_rdata_q;

        unique case (state_q)
            CLEAR: begin
                we_c    = 1'b1;
                waddr_c = clr_addr_q;
                if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d    = RUN;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            RUN: begin
                if (bus.clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end else begin
                    a_wg = a_wc & (~b_wc | ~wr_prio_q);
                    b_wg = b_wc & (~a_wc | wr_prio_q);
                    a_rg = a_rc & (~b_rc | ~rd_prio_q);
                    b_rg = b_rc & (~a_rc | rd_prio_q);
                    if (a_wc & b_wc) wr_prio_d = ~wr_prio_q;
                    if (a_rc & b_rc) rd_prio_d = ~rd_prio_q;

                    we_c    = a_wg | b_wg;
                    waddr_c = b_wg ? bus.b_addr : bus.a_addr;
                    wdata_c = b_wg ? bus.b_wdata : bus.a_wdata;
                    re_c    = a_rg | b_rg;
                    raddr_c = b_rg ? bus.b_addr : bus.a_addr;

                    a_pend_d = a_rg;
                    b_pend_d = b_rg;
                    byp_d    = we_c & re_c & (waddr_c == raddr_c);
                    if (byp_d) byp_data_d = wdata_c;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            wr_prio_q  <= 1'b0;
            rd_prio_q  <= 1'b0;
            a_pend_q   <= 1'b0;
            b_pend_q   <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_prio_q  <= wr_prio_d;
            rd_prio_q  <= rd_prio_d;
            a_pend_q   <= a_pend_d;
            b_pend_q   <= b_pend_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign bus.init_done = (state_q == RUN);
    assign bus.a_gnt     = ~reset & (a_wg | a_rg);
    assign bus.b_gnt     = ~reset & (b_wg | b_rg);
    assign bus.mem_we    = ~reset & we_c;
    assign bus.mem_re    = ~reset & re_c;
    assign bus.mem_waddr = waddr_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.mem_raddr = raddr_c;
    assign bus.a_rvalid  = a_pend_q;
    assign bus.b_rvalid  = b_pend_q;
    assign bus.a_rdata   = a_rdata_d;
    assign bus.b_rdata   = b_rdata_d;
endmodule

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
- Sequences and shares one 64-bit x 256-entry dual-port data memory between two requesters: A (CPU pipeline) and B (host/network side).
- The memory has one synchronous write port and one synchronous read port (1-cycle read latency). Reads and writes are arbitrated independently, with round-robin on contention.
- On reset or on request, the block zero-fills the whole memory before granting any access.

Parameters:
- DATA_WIDTH, 64, memory word width
- ADDR_WIDTH, 8, address width
- DEPTH, 256, number of entries; must equal 2**ADDR_WIDTH

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- clear_req  input  1  pulse: re-zero the entire memory
- init_done  output  1  high when in RUN state
- a_req  input  1  requester A access request; held until granted
- a_we  input  1  1 = write, 0 = read
- a_addr  input  ADDR_WIDTH  A address
- a_wdata  input  DATA_WIDTH  A write data
- a_gnt  output  1  combinational grant; access performed this cycle
- a_rvalid  output  1  A read data valid (registered)
- a_rdata  output  DATA_WIDTH  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- mem_we  output  1  memory write enable
- mem_waddr  output  ADDR_WIDTH  memory write address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_re  output  1  memory read enable
- mem_raddr  output  ADDR_WIDTH  memory read address
- mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_re

Behaviour:
- Reset (async): state = CLEAR, clr_addr = 0, wr_prio = A, rd_prio = A.
- Reset values of registered outputs: init_done = 0, a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0.
- During reset, all combinational outputs (gnt, mem_we, mem_re) are 0.
- Reset mid-operation aborts any in-flight read; no rvalid is issued for it.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle: mem_we = 1, mem_waddr = clr_addr, mem_wdata = 0; mem_re = 0; no grants.
  - clr_addr increments each cycle.
  - After the cycle with clr_addr = DEPTH-1, go to RUN. CLEAR lasts exactly DEPTH cycles.
  - clr_addr wraps to 0 on exit.
  - clear_req is ignored while in CLEAR.
- RUN:
  - init_done = 1.
  - clear_req = 1: no grants that cycle; next state = CLEAR with clr_addr = 0.
  - A read granted in the previous cycle still returns its rvalid/rdata.
- Write arbitration (RUN, clear_req = 0):
  - Candidates are requesters with req & we.
  - Single candidate: it is granted.
  - Both candidates: wr_prio holder is granted, then wr_prio flips to the loser at the clock edge.
  - Uncontested grants do not change wr_prio.
  - Granted write drives mem_we = 1, mem_waddr and mem_wdata from that requester.
- Read arbitration:
  - Same rules using req & ~we and rd_prio, which is independent of wr_prio.
  - Granted read drives mem_re = 1 and mem_raddr.
  - mem_we and mem_re are 0 when nothing is granted on that port.
- Parallel access: one write and one read may be granted in the same cycle (e.g. A write and B read).
- Read return:
  - Read granted at cycle T: the requester's rvalid = 1 for exactly cycle T+1, with rdata = mem_rdata.
  - The other requester's rvalid stays 0.
  - rdata holds its last value when rvalid = 0.
- Same-cycle hazard: if the granted read and the granted write target the same address in cycle T, rdata at T+1 equals that cycle's write data (bypass); memory read-during-write behaviour is ignored.
- Back-to-back operation: a requester may be granted every cycle; reads are fully pipelined (one per cycle per port).
- Ungranted requests stay pending with no side effects. A requester must hold req/we/addr/wdata stable until gnt.

Test Plan:
- Reset release -> mem_we = 1 for exactly 256 cycles, addresses 0..255, wdata 0; init_done rises the next cycle. A read of addr 0x7F then returns 0.
- A writes 0xDEADBEEF_00000001 to 0x10, then A reads 0x10 -> a_gnt same cycle as req; a_rvalid one cycle after the read grant with that data; b_rvalid stays 0.
- A and B both write every cycle for 4 cycles (addrs 0x20 and 0x21) -> grants alternate A, B, A, B. Then both read every cycle -> rd_prio starts at A, grants alternate A, B, A, B.
- Same cycle: A writes 0x55 to 0x30 while B reads 0x30 (old value 0) -> both granted; b_rdata = 0x55 at T+1.
- clear_req while B has a read granted the previous cycle -> B's rvalid still delivered; no grants that cycle; 256 clear writes follow; a subsequent read of 0x10 returns 0.
- Assert reset mid-CLEAR (clr_addr = 100) and during a pending read -> outputs drop immediately, no rvalid; CLEAR restarts at address 0.
